// File: rtl/mop_sequencer.sv
`default_nettype none
// ============================================================================
// mop_sequencer : buffers cracked micro-op bundles, issues OUT_W lanes/cycle.
// Optional stats counters when MOP_SEQ_STATS_EN is defined.  Rev 1.0
// ============================================================================
module mop_sequencer #(
  parameter int IN_MAX = 8,
  parameter int OUT_W  = 2,
  parameter int DEPTH  = 16,
  parameter int MOP_W  = 128
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(IN_MAX+1)-1:0]   in_cnt,
  input  logic                          in_err,
  input  logic [IN_MAX*MOP_W-1:0]       in_mops,
  output logic [OUT_W-1:0]              out_valid,
  output logic [OUT_W*MOP_W-1:0]        out_mops,
  output logic [OUT_W-1:0]              out_eoi,
  input  logic                          out_ready,
  output logic                          err_halt,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
`ifdef MOP_SEQ_STATS_EN
  ,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(IN_MAX + 1);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]     occ_q, occ_d;
  logic [MOP_W-1:0]  mem_q [DEPTH];
  logic [MOP_W-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  eoi_q, eoi_d;

  logic              bad_bundle;
  logic              accept;
  logic              push_en;
  logic [CW-1:0]     push_cnt;
  logic [OW-1:0]     pop_cnt;
  logic [OW-1:0]     free_cnt;

  // Handshake and per-cycle push/pop amounts
  always_comb begin
    free_cnt   = OW'(DEPTH) - occ_q;
    in_ready   = reset_n && (state_q == RUN) && (free_cnt >= OW'(IN_MAX)) && !flush;
    bad_bundle = in_err || (in_cnt > CW'(IN_MAX));
    accept     = in_valid && in_ready;
    push_en    = accept && !bad_bundle;
    push_cnt   = push_en ? in_cnt : '0;
    if (!out_ready) begin
      pop_cnt = '0;
    end else if (occ_q >= OW'(OUT_W)) begin
      pop_cnt = OW'(OUT_W);
    end else begin
      pop_cnt = occ_q;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_cnt);
    wr_ptr_d = wr_ptr_q + PW'(push_cnt);
    occ_d    = occ_q + OW'(push_cnt) - pop_cnt;
    state_d  = state_q;
    if (accept && bad_bundle) begin
      state_d = HALT;
    end
    // Flush wins over any same-cycle push, pop or error
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      state_d  = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage write: lanes 0..in_cnt-1 land at consecutive (wrapping) slots
  always_comb begin : p_store
    logic [PW-1:0] idx;
    idx   = '0;
    mem_d = mem_q;
    eoi_d = eoi_q;
    for (int i = 0; i < IN_MAX; i++) begin
      if (push_en && (CW'(i) < in_cnt)) begin
        idx        = wr_ptr_q + PW'(i);
        mem_d[idx] = in_mops[i*MOP_W +: MOP_W];
        eoi_d[idx] = (CW'(i) == (in_cnt - CW'(1)));
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    eoi_q <= eoi_d;
  end

  always_comb begin : p_issue
    logic [PW-1:0] ridx;
    ridx      = '0;
    out_valid = '0;
    out_mops  = '0;
    out_eoi   = '0;
    for (int i = 0; i < OUT_W; i++) begin
      ridx         = rd_ptr_q + PW'(i);
      out_valid[i] = (occ_q > OW'(i));
      if (out_valid[i]) begin
        out_mops[i*MOP_W +: MOP_W] = mem_q[ridx];
        out_eoi[i]                 = eoi_q[ridx];
      end
    end
  end

  assign err_halt  = (state_q == HALT);
  assign occupancy = occ_q;

`ifdef MOP_SEQ_STATS_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] stall_q, stall_d;
  logic [32:0] issued_sum;

  always_comb begin
    issued_sum = {1'b0, issued_q} + (flush ? 33'd0 : 33'(pop_cnt));
    issued_d   = issued_sum[32] ? '1 : issued_sum[31:0];
    stall_d    = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/mop_sequencer.md
MOP_SEQUENCER -- requirements
Module: mop_sequencer

Interface
REQ-001 SHALL have parameter IN_MAX, default 8: max micro-ops per cracked instruction bundle.
REQ-002 SHALL have parameter OUT_W, default 2: micro-op lanes issued per cycle (1..IN_MAX).
REQ-003 SHALL have parameter DEPTH, default 16: buffer entries, power of two, >= IN_MAX.
REQ-004 SHALL have parameter MOP_W, default 128: bit width of one micro_op_t.
REQ-005 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1: synchronous discard of all buffered micro-ops and error state.
REQ-008 SHALL have port in_valid, input, 1: bundle offered.
REQ-009 SHALL have port in_ready, output, 1: bundle accepted when in_valid && in_ready.
REQ-010 SHALL have port in_cnt, input, $clog2(IN_MAX+1): valid micro-ops in bundle, lane 0 first.
REQ-011 SHALL have port in_err, input, 1: cracker reported -1 (unsupported or invalid instruction).
REQ-012 SHALL have port in_mops, input, IN_MAX*MOP_W: bundle; lane i at bits [i*MOP_W +: MOP_W].
REQ-013 SHALL have port out_valid, output, OUT_W: per-lane valid, always contiguous from lane 0.
REQ-014 SHALL have port out_mops, output, OUT_W*MOP_W: issued micro-ops, oldest in lane 0.
REQ-015 SHALL have port out_eoi, output, OUT_W: lane holds last micro-op of its instruction.
REQ-016 SHALL have port out_ready, input, 1: when high, every valid lane is consumed that cycle.
REQ-017 SHALL have port err_halt, output, 1: sequencer halted on an error bundle.
REQ-018 SHALL have port occupancy, output, $clog2(DEPTH+1): buffered micro-op count.

Function
REQ-019 SHALL be a circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter.
REQ-020 SHALL have a state machine with states RUN and HALT: RUN->HALT on an accepted bundle with in_err=1; HALT->RUN only on flush.
REQ-021 SHALL drive in_ready = (state==RUN) && (DEPTH - occupancy >= IN_MAX) && !flush, independent of in_valid.
REQ-022 SHALL, on an accepted bundle with in_err=0 and in_cnt=N>0, write lanes 0..N-1 at wr_ptr..wr_ptr+N-1 in one cycle, setting eoi only on lane N-1.
REQ-023 SHALL accept and discard a bundle with in_cnt=0 (e.g. nop) without writing entries.
REQ-024 SHALL discard all micro-ops of an accepted error bundle and assert err_halt from the next cycle.
REQ-025 SHALL drive out_valid[i]=1 iff occupancy > i; out_mops/out_eoi come combinationally from entries rd_ptr+i (registered storage, zero-cycle read).
REQ-026 SHALL advance rd_ptr by popcount(out_valid) when out_ready=1; a lane with out_valid=0 SHALL output all-zero micro-op and eoi=0.
REQ-027 SHALL update occupancy as occupancy + pushed - popped when push and pop happen in the same cycle.
REQ-028 SHALL give one-cycle latency: a micro-op written at edge k SHALL be visible on out lanes after edge k.
REQ-029 SHALL continue draining buffered micro-ops in HALT; it only refuses new bundles.
REQ-030 SHALL, on flush, set pointers, occupancy and err_halt to 0 and state to RUN at the next edge; flush SHALL override same-cycle push and pop.
REQ-031 SHALL treat in_cnt > IN_MAX as in_err=1.

Reset
REQ-032 SHALL, on reset_n low, asynchronously clear rd_ptr, wr_ptr and occupancy, set state to RUN and err_halt to 0, and drive out_valid=0 and in_ready=0 while reset is held.
REQ-033 SHALL leave storage contents uninitialised; outputs SHALL depend only on out_valid-qualified entries.

Configuration
REQ-034 SHALL add, when MOP_SEQ_STATS_EN is defined, outputs stat_issued (32b, total micro-ops popped) and stat_stall (32b, cycles with in_valid && !in_ready), both saturating, cleared by reset, unaffected by flush.
REQ-035 SHALL NOT have these ports or counters when MOP_SEQ_STATS_EN is undefined; function is otherwise identical.

Verification
REQ-036 SHALL cover a 5-mop bundle into an empty buffer with out_ready=1 and OUT_W=2 -> lanes 2,2,1 over three cycles; eoi only on the fifth; occupancy 5,3,1,0.
REQ-037 SHALL cover occupancy=DEPTH-IN_MAX+1 -> in_ready=0; one pop of 2 -> in_ready=1 next cycle.
REQ-038 SHALL cover a push of 4 and a pop of 2 in the same cycle at occupancy 3 -> occupancy 5.
REQ-039 SHALL cover an in_err bundle with 6 mops buffered -> err_halt=1, in_ready=0, all 6 still issued; then flush -> occupancy 0, err_halt 0, in_ready 1.
REQ-040 SHALL cover wr_ptr=DEPTH-2 with a push of 4 -> entries wrap to indices DEPTH-2, DEPTH-1, 0, 1 and issue in order.
REQ-041 SHALL cover reset_n low mid-drain with occupancy 7 -> out_valid=0 immediately; after release, occupancy=0, and with MOP_SEQ_STATS_EN stat counters=0.
